rx_ts_resp_merge: RTL and testbench

Multi-channel, single-clock timestamp-to-DMA-response merger for the RX DMA path. Captures the RX timestamp of each packet at SOP into a per-channel FIFO, then pops the matching entry when that channel's DMA response returns and inserts it into the response word. Each channel has a stale-entry timeout flush, an overflow flag and a miss indication. It generalises the single-channel timestamp path to NUM_CH channels with configurable depth and field placement.

---
 rtl/rx_ts_pkg.sv | 20 ++
 rtl/rx_ts_chan_fifo.sv | 78 +++++++
 rtl/rx_ts_resp_merge.sv | 128 ++++++++++++
 tb/tb_rx_ts_resp_merge.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_ts_pkg.sv
// Shared constants, types and helpers for the RX timestamp/response merge path.
package rx_ts_pkg;

   localparam int RESP_WIDTH_DEF    = 256;
   localparam int RESP_LO_WIDTH_DEF = 128;
   localparam int TS_WIDTH_DEF      = 96;
   localparam int TS_LSB_DEF        = 160;
   localparam int TS_MAX_WIDTH      = 128;

   // Selected timestamp for one response; hit=0 means the field is zeroed (miss).
   typedef struct packed {
      logic                    hit;
      logic [TS_MAX_WIDTH-1:0] ts;
   } ts_entry_t;

   function automatic int lvl_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/rx_ts_chan_fifo.sv
// Per-channel timestamp FIFO with stale-entry timeout flush and sticky overflow flag.
module rx_ts_chan_fifo
   import rx_ts_pkg::*;
#(
   parameter  int TS_WIDTH      = TS_WIDTH_DEF,
   parameter  int DEPTH         = 8,
   parameter  int TO_CNTR_WIDTH = 20,
   localparam int LVL_W         = lvl_width(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic [TS_WIDTH-1:0] din,
   input  logic                pop,
   input  logic                stat_clr,
   output logic [TS_WIDTH-1:0] head,
   output logic                empty,
   output logic                full,
   output logic [LVL_W-1:0]    level,
   output logic                flush_pulse,
   output logic                ovf
);

   localparam int AW = LVL_W - 1;

   logic [LVL_W-1:0]         wr_ptr;
   logic [LVL_W-1:0]         rd_ptr;
   logic [TS_WIDTH-1:0]      mem [DEPTH];
   logic [TO_CNTR_WIDTH-1:0] to_cnt;
   logic                     do_pop;
   logic                     do_push;
   logic                     flush;
   logic                     drop;
   logic [AW-1:0]            wr_idx;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign head    = mem[rd_ptr[AW-1:0]];
   assign do_pop  = pop & ~empty;
   assign flush   = (&to_cnt) & ~empty & ~do_pop;
   // A flush frees the whole FIFO, so a capture in that cycle always fits at slot 0.
   assign do_push = push & (flush | ~full | do_pop);
   assign drop    = push & ~do_push;
   assign wr_idx  = flush ? '0 : wr_ptr[AW-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= LVL_W'(do_push);
      end else begin
         if (do_push) wr_ptr <= wr_ptr + LVL_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + LVL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_idx] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt      <= '0;
         flush_pulse <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         if (empty | do_pop | flush) to_cnt <= '0;
         else                        to_cnt <= to_cnt + TO_CNTR_WIDTH'(1);
         flush_pulse <= flush;
         if (drop)          ovf <= 1'b1;
         else if (stat_clr) ovf <= 1'b0;
      end
   end

endmodule

// File: rtl/rx_ts_resp_merge.sv
// Multi-channel merge of captured RX timestamps into returning DMA response words.
module rx_ts_resp_merge
   import rx_ts_pkg::*;
#(
   parameter  int NUM_CH        = 8,
   parameter  int TS_WIDTH      = TS_WIDTH_DEF,
   parameter  int RESP_WIDTH    = RESP_WIDTH_DEF,
   parameter  int RESP_LO_WIDTH = RESP_LO_WIDTH_DEF,
   parameter  int TS_LSB        = TS_LSB_DEF,
   parameter  int DEPTH         = 8,
   parameter  int TO_CNTR_WIDTH = 20,
   localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int LVL_W         = lvl_width(DEPTH)
) (
   input  logic                    st_clk,
   input  logic                    st_rst_n,
   input  logic                    cap_valid,
   input  logic [CH_W-1:0]         cap_ch,
   input  logic [TS_WIDTH-1:0]     cap_ts,
   input  logic                    in_resp_valid,
   output logic                    in_resp_ready,
   input  logic [CH_W-1:0]         in_resp_ch,
   input  logic [RESP_WIDTH-1:0]   in_resp_data,
   output logic                    out_resp_valid,
   input  logic                    out_resp_ready,
   output logic [CH_W-1:0]         out_resp_ch,
   output logic [RESP_WIDTH-1:0]   out_resp_data,
   output logic                    out_resp_ts_miss,
   output logic [NUM_CH-1:0]       ts_ovf,
   output logic [NUM_CH-1:0]       ts_flush,
   output logic [NUM_CH*LVL_W-1:0] ts_level,
   input  logic                    stat_clr
);

   if (TS_LSB < RESP_LO_WIDTH || TS_LSB + TS_WIDTH > RESP_WIDTH) begin : g_bad_field
      $error("rx_ts_resp_merge: timestamp field overlaps low bits or exceeds response width");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("rx_ts_resp_merge: DEPTH must be a power of two and at least 2");
   end
   if (TS_WIDTH > TS_MAX_WIDTH) begin : g_bad_ts
      $error("rx_ts_resp_merge: TS_WIDTH exceeds TS_MAX_WIDTH");
   end

   logic                  acc;
   logic                  sel_empty;
   logic                  cap_hit;
   logic                  bypass;
   ts_entry_t             sel;
   logic [NUM_CH-1:0]     push;
   logic [NUM_CH-1:0]     pop;
   logic [NUM_CH-1:0]     empty;
   logic [NUM_CH-1:0]     full;
   logic [TS_WIDTH-1:0]   heads [NUM_CH];
   logic [RESP_WIDTH-1:0] resp_next;

   assign in_resp_ready = ~out_resp_valid | out_resp_ready;
   assign acc           = in_resp_valid & in_resp_ready;
   assign cap_hit       = cap_valid & (cap_ch == in_resp_ch);
   // Bypass only when the responding FIFO is empty; otherwise the capture queues behind.
   assign bypass        = acc & sel_empty & cap_hit;

   always_comb begin
      sel       = '0;
      sel_empty = 1'b1;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (in_resp_ch == CH_W'(c)) begin
            sel_empty = empty[c];
            sel.ts    = TS_MAX_WIDTH'(heads[c]);
         end
      end
      if (!sel_empty) begin
         sel.hit = 1'b1;
      end else if (cap_hit) begin
         sel.hit = 1'b1;
         sel.ts  = TS_MAX_WIDTH'(cap_ts);
      end else begin
         sel = '0;
      end
   end

   always_comb begin
      resp_next                       = '0;
      resp_next[RESP_LO_WIDTH-1:0]    = in_resp_data[RESP_LO_WIDTH-1:0];
      resp_next[TS_LSB +: TS_WIDTH]   = sel.ts[TS_WIDTH-1:0];
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign push[c] = cap_valid & (cap_ch == CH_W'(c)) & ~bypass;
      assign pop[c]  = acc & (in_resp_ch == CH_W'(c)) & ~empty[c];

      rx_ts_chan_fifo #(
         .TS_WIDTH      (TS_WIDTH),
         .DEPTH         (DEPTH),
         .TO_CNTR_WIDTH (TO_CNTR_WIDTH)
      ) u_fifo (
         .clk         (st_clk),
         .rst_n       (st_rst_n),
         .push        (push[c]),
         .din         (cap_ts),
         .pop         (pop[c]),
         .stat_clr    (stat_clr),
         .head        (heads[c]),
         .empty       (empty[c]),
         .full        (full[c]),
         .level       (ts_level[c*LVL_W +: LVL_W]),
         .flush_pulse (ts_flush[c]),
         .ovf         (ts_ovf[c])
      );
   end

   always_ff @(posedge st_clk or negedge st_rst_n) begin
      if (!st_rst_n) begin
         out_resp_valid   <= 1'b0;
         out_resp_data    <= '0;
         out_resp_ch      <= '0;
         out_resp_ts_miss <= 1'b0;
      end else if (acc) begin
         out_resp_valid   <= 1'b1;
         out_resp_data    <= resp_next;
         out_resp_ch      <= in_resp_ch;
         out_resp_ts_miss <= ~sel.hit;
      end else if (out_resp_ready) begin
         out_resp_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rx_ts_resp_merge.sv
// Directed self-checking bench for rx_ts_resp_merge (timeout shortened to 16 cycles).
module tb_rx_ts_resp_merge;

   localparam int NUM_CH = 8;
   localparam int CH_W   = 3;
   localparam int LVL_W  = 4;

   logic                    st_clk = 1'b0;
   logic                    st_rst_n = 1'b1;
   logic                    cap_valid = 1'b0;
   logic [CH_W-1:0]         cap_ch = '0;
   logic [95:0]             cap_ts = '0;
   logic                    in_resp_valid = 1'b0;
   logic                    in_resp_ready;
   logic [CH_W-1:0]         in_resp_ch = '0;
   logic [255:0]            in_resp_data = '0;
   logic                    out_resp_valid;
   logic                    out_resp_ready = 1'b0;
   logic [CH_W-1:0]         out_resp_ch;
   logic [255:0]            out_resp_data;
   logic                    out_resp_ts_miss;
   logic [NUM_CH-1:0]       ts_ovf;
   logic [NUM_CH-1:0]       ts_flush;
   logic [NUM_CH*LVL_W-1:0] ts_level;
   logic                    stat_clr = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   rx_ts_resp_merge #(
      .NUM_CH        (8),
      .TS_WIDTH      (96),
      .RESP_WIDTH    (256),
      .RESP_LO_WIDTH (128),
      .TS_LSB        (160),
      .DEPTH         (8),
      .TO_CNTR_WIDTH (4)
   ) dut (
      .st_clk           (st_clk),
      .st_rst_n         (st_rst_n),
      .cap_valid        (cap_valid),
      .cap_ch           (cap_ch),
      .cap_ts           (cap_ts),
      .in_resp_valid    (in_resp_valid),
      .in_resp_ready    (in_resp_ready),
      .in_resp_ch       (in_resp_ch),
      .in_resp_data     (in_resp_data),
      .out_resp_valid   (out_resp_valid),
      .out_resp_ready   (out_resp_ready),
      .out_resp_ch      (out_resp_ch),
      .out_resp_data    (out_resp_data),
      .out_resp_ts_miss (out_resp_ts_miss),
      .ts_ovf           (ts_ovf),
      .ts_flush         (ts_flush),
      .ts_level         (ts_level),
      .stat_clr         (stat_clr)
   );

   always #5 st_clk = ~st_clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Expected merged word: upper input garbage dropped, ts placed at bit 160.
   function automatic logic [255:0] mk(input logic [95:0] ts, input logic [127:0] lo);
      logic [255:0] r;
      r = '0;
      r[127:0]    = lo;
      r[160 +: 96] = ts;
      return r;
   endfunction

   function automatic logic [3:0] lvl(input int c);
      return ts_level[c*LVL_W +: LVL_W];
   endfunction

   task automatic tick();
      @(posedge st_clk);
      #1;
   endtask

   task automatic cap(input logic v, input int ch, input logic [95:0] ts);
      cap_valid = v;
      cap_ch    = CH_W'(ch);
      cap_ts    = ts;
   endtask

   task automatic resp(input logic v, input int ch, input logic [127:0] lo);
      in_resp_valid = v;
      in_resp_ch    = CH_W'(ch);
      in_resp_data  = {{4{32'hDEADBEEF}}, lo};
   endtask

   initial begin
      // reset state
      #3 st_rst_n = 1'b0;
      tick();
      tick();
      check("rst_valid", 256'(out_resp_valid), 256'd0);
      check("rst_data", out_resp_data, 256'd0);
      check("rst_ch", 256'(out_resp_ch), 256'd0);
      check("rst_miss", 256'(out_resp_ts_miss), 256'd0);
      check("rst_ovf", 256'(ts_ovf), 256'd0);
      check("rst_flush", 256'(ts_flush), 256'd0);
      check("rst_level", 256'(ts_level), 256'd0);
      check("rst_ready", 256'(in_resp_ready), 256'd1);
      @(negedge st_clk);
      st_rst_n = 1'b1;
      out_resp_ready = 1'b1;

      // capture then matching response
      @(negedge st_clk); cap(1, 3, 96'h11);
      tick();
      check("t1_lvl_cap", 256'(lvl(3)), 256'd1);
      @(negedge st_clk); cap(0, 0, 0); resp(1, 3, 128'hAB);
      tick();
      check("t1_valid", 256'(out_resp_valid), 256'd1);
      check("t1_ch", 256'(out_resp_ch), 256'd3);
      check("t1_data", out_resp_data, mk(96'h11, 128'hAB));
      check("t1_miss", 256'(out_resp_ts_miss), 256'd0);
      check("t1_lvl_pop", 256'(lvl(3)), 256'd0);

      // empty FIFO: miss, then same-cycle bypass
      @(negedge st_clk); resp(1, 5, 128'hCD);
      tick();
      check("t2_miss_data", out_resp_data, mk(96'h0, 128'hCD));
      check("t2_miss_flag", 256'(out_resp_ts_miss), 256'd1);
      check("t2_miss_ch", 256'(out_resp_ch), 256'd5);
      @(negedge st_clk); resp(1, 5, 128'hCE); cap(1, 5, 96'h22);
      tick();
      check("t2_byp_data", out_resp_data, mk(96'h22, 128'hCE));
      check("t2_byp_miss", 256'(out_resp_ts_miss), 256'd0);
      check("t2_byp_lvl", 256'(lvl(5)), 256'd0);
      @(negedge st_clk); resp(0, 0, 0); cap(0, 0, 0);
      tick();
      check("t2_idle_valid", 256'(out_resp_valid), 256'd0);
      check("t2_idle_lvl", 256'(lvl(5)), 256'd0);

      // overflow, clear, set-wins, full with pop+push, drain order
      for (int i = 0; i < 9; i++) begin
         @(negedge st_clk); cap(1, 0, 96'h100 + 96'(i));
         tick();
      end
      check("t3_full_lvl", 256'(lvl(0)), 256'd8);
      check("t3_ovf", 256'(ts_ovf[0]), 256'd1);
      @(negedge st_clk); cap(0, 0, 0); stat_clr = 1'b1;
      tick();
      check("t3_clr", 256'(ts_ovf[0]), 256'd0);
      @(negedge st_clk); cap(1, 0, 96'h1FF);
      tick();
      check("t3_set_wins", 256'(ts_ovf[0]), 256'd1);
      check("t3_drop_lvl", 256'(lvl(0)), 256'd8);
      @(negedge st_clk); cap(0, 0, 0);
      tick();
      check("t3_clr2", 256'(ts_ovf[0]), 256'd0);
      @(negedge st_clk); stat_clr = 1'b0; cap(1, 0, 96'h200); resp(1, 0, 128'h10);
      tick();
      check("t3_fullpp_data", out_resp_data, mk(96'h100, 128'h10));
      check("t3_fullpp_lvl", 256'(lvl(0)), 256'd8);
      check("t3_fullpp_ovf", 256'(ts_ovf[0]), 256'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge st_clk); cap(0, 0, 0); resp(1, 0, 128'h20 + 128'(i));
         tick();
         check($sformatf("t3_drain%0d", i), out_resp_data,
               mk((i < 7) ? 96'h101 + 96'(i) : 96'h200, 128'h20 + 128'(i)));
      end
      @(negedge st_clk); resp(0, 0, 0);
      tick();
      check("t3_empty_lvl", 256'(lvl(0)), 256'd0);

      // timeout flush after 16 idle cycles
      @(negedge st_clk); cap(1, 1, 96'h33);
      tick();
      @(negedge st_clk); cap(0, 0, 0);
      repeat (15) tick();
      check("t4_pre_lvl", 256'(lvl(1)), 256'd1);
      check("t4_pre_flush", 256'(ts_flush[1]), 256'd0);
      tick();
      check("t4_flush", 256'(ts_flush), 256'h2);
      check("t4_flush_lvl", 256'(lvl(1)), 256'd0);
      tick();
      check("t4_flush_end", 256'(ts_flush[1]), 256'd0);

      // pop in the would-be flush cycle prevents the flush
      @(negedge st_clk); cap(1, 1, 96'h44);
      tick();
      @(negedge st_clk); cap(0, 0, 0);
      repeat (15) tick();
      check("t5_pre_lvl", 256'(lvl(1)), 256'd1);
      @(negedge st_clk); resp(1, 1, 128'h55);
      tick();
      check("t5_data", out_resp_data, mk(96'h44, 128'h55));
      check("t5_miss", 256'(out_resp_ts_miss), 256'd0);
      check("t5_lvl", 256'(lvl(1)), 256'd0);
      @(negedge st_clk); resp(0, 0, 0);
      tick();
      check("t5_noflush", 256'(ts_flush[1]), 256'd0);

      // back-pressure and FIFO order
      for (int i = 0; i < 3; i++) begin
         @(negedge st_clk); cap(1, 4, 96'h51 + 96'(i));
         tick();
      end
      @(negedge st_clk); cap(0, 0, 0); out_resp_ready = 1'b0; resp(1, 4, 128'h61);
      tick();
      check("t6_first", out_resp_data, mk(96'h51, 128'h61));
      @(negedge st_clk); resp(1, 4, 128'h62);
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("t6_ready%0d", i), 256'(in_resp_ready), 256'd0);
         check($sformatf("t6_hold%0d", i), out_resp_data, mk(96'h51, 128'h61));
         check($sformatf("t6_lvl%0d", i), 256'(lvl(4)), 256'd2);
      end
      @(negedge st_clk); out_resp_ready = 1'b1;
      tick();
      check("t6_rel1", out_resp_data, mk(96'h52, 128'h62));
      @(negedge st_clk); resp(1, 4, 128'h63);
      tick();
      check("t6_rel2", out_resp_data, mk(96'h53, 128'h63));
      check("t6_rel2_valid", 256'(out_resp_valid), 256'd1);
      check("t6_lvl_end", 256'(lvl(4)), 256'd0);
      @(negedge st_clk); resp(0, 0, 0);
      tick();
      check("t6_drained", 256'(out_resp_valid), 256'd0);

      // asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) begin
         @(negedge st_clk); cap(1, 2, 96'h71 + 96'(i));
         if (i == 2) resp(1, 6, 128'h77);
         tick();
      end
      check("t7_pre_lvl", 256'(lvl(2)), 256'd3);
      check("t7_pre_valid", 256'(out_resp_valid), 256'd1);
      cap(0, 0, 0); resp(0, 0, 0);
      #2 st_rst_n = 1'b0;
      #1;
      check("t7_valid", 256'(out_resp_valid), 256'd0);
      check("t7_data", out_resp_data, 256'd0);
      check("t7_ch", 256'(out_resp_ch), 256'd0);
      check("t7_miss", 256'(out_resp_ts_miss), 256'd0);
      check("t7_level", 256'(ts_level), 256'd0);
      check("t7_ready", 256'(in_resp_ready), 256'd1);
      @(negedge st_clk); st_rst_n = 1'b1; resp(1, 2, 128'h81);
      tick();
      check("t7_post_data", out_resp_data, mk(96'h0, 128'h81));
      check("t7_post_miss", 256'(out_resp_ts_miss), 256'd1);
      check("t7_post_ch", 256'(out_resp_ch), 256'd2);
      @(negedge st_clk); resp(0, 0, 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
